word_framer: RTL and testbench
==============================

# word_framer

Consumes the word boundaries produced by the word clipping pipeline and splits each clipped word into fixed-length, overlapping analysis frames for the downstream feature-extraction stage. It is the receiving end of the clipper's valid/ack word handshake: it acknowledges each word and emits one frame descriptor (start/end byte address) per frame over a valid/ready stream. It forwards end-of-utterance completion once the clipper is done and all frames have been issued.

## Interface
- FRAME_LEN, 400, samples per frame (25 ms @ 16 kHz), ≥1
- FRAME_HOP, 160, samples between frame starts, 1..FRAME_LEN
- ADDR_W, 32, byte-address width
- IDX_W, 16, frame-index width
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_word_valid  in  1  clipper has a word (level, held until ack)
- i_word_start  in  ADDR_W  byte address of first sample of word
- i_word_end  in  ADDR_W  byte address of last sample of word (inclusive)
- i_clip_done  in  1  clipper finished the utterance (level)
- o_word_ack  out  1  one-cycle pulse: word captured
- o_frame_valid  out  1  frame descriptor valid
- i_frame_ready  in  1  consumer accepts descriptor
- o_frame_start  out  ADDR_W  byte address of frame's first sample
- o_frame_end  out  ADDR_W  byte address of frame's last sample (inclusive)
- o_frame_idx  out  IDX_W  frame number within current word, from 0
- o_frame_last  out  1  final frame of current word
- o_frame_pad  out  1  frame extends past word end; consumer zero-fills
- o_done  out  1  sticky: all words framed and clipper done

## Operation
- Samples are 16-bit; sample stride SAMPLE_BYTES = 2. Frame k: start = word_start + k·FRAME_HOP·2, end = start + (FRAME_LEN−1)·2.
- Fit test: end ≤ word_end, computed at ADDR_W+1 bits; a carry out of ADDR_W means "does not fit" (no wrap-around frames).
- FSM states: IDLE, CHECK, EMIT, DONE.
- IDLE: if i_word_valid, latch start/end, pulse o_word_ack, go to CHECK. Otherwise, if i_clip_done, go to DONE. A word has priority over done when both are present.
- CHECK: if i_word_end < i_word_start, discard the word and go to IDLE. Otherwise, if frame 0 is emittable, load frame 0 and go to EMIT; else go to IDLE (zero frames).
- EMIT: o_frame_valid=1. On valid&&ready: if o_frame_last, go to IDLE; else load frame k+1 (idx+1).
- o_frame_last is precomputed on load: frame k+1 is not emittable.
- o_frame_idx saturates at 2^IDX_W−1.
- DONE: o_done=1; stays there until i_rst; i_word_valid is ignored.

## Timing
- Reset values: o_word_ack=0, o_frame_valid=0, o_frame_start/end/idx=0, o_frame_last=0, o_frame_pad=0, o_done=0; state IDLE.
- i_word_valid sampled in IDLE at cycle N → o_word_ack high in N+1 (CHECK) → first o_frame_valid in N+2.
- One frame per cycle while i_frame_ready=1.
- Descriptor outputs are held stable while o_frame_valid && !i_frame_ready. o_frame_valid does not drop until the transfer completes.
- The handshake of the last frame at cycle M returns the block to IDLE in M+1; the next word is acked at M+2 at the earliest.
- i_rst mid-word drops the in-flight frame with no partial output. All outputs return to reset values the next cycle.

## Configuration
- WORD_FRAMER_ZERO_PAD_EN defined:
  - A frame is emittable when start ≤ word_end.
  - The final partial frame is emitted with o_frame_pad=1 and a full-length o_frame_end.
  - A word shorter than FRAME_LEN yields exactly one padded frame.
- WORD_FRAMER_ZERO_PAD_EN undefined:
  - Only full frames are emitted.
  - o_frame_pad is tied 0.
  - Trailing partial samples are dropped.

## Structure
- word_framer_pkg: state enum, SAMPLE_BYTES, default FRAME_LEN/FRAME_HOP constants.
- One combinational sub-module, frame_addr_gen:
  - Inputs: word start/end and frame index.
  - Outputs: frame start/end, fit flag, pad flag, next-fit flag.
  - Shared by the CHECK and EMIT paths.

## Test plan
- Word 0x1000..0x159E (720 samples), ready=1, no pad → ack at N+1. Three frames:
  - starts 0x1000/0x1140/0x1280
  - ends 0x131E/0x145E/0x159E
  - idx 0..2; last on idx 2 only
- Same word with WORD_FRAMER_ZERO_PAD_EN → fourth frame: start 0x13C0, end 0x16DE, pad=1, last=1; first three frames have pad=0.
- Word 0x2000..0x20C6 (100 samples):
  - no pad → ack, zero frames, back in IDLE
  - with pad → one frame 0x2000..0x231E, pad=1, last=1
- Backpressure: ready low for 5 cycles during frame 1 → start/end/idx/last held constant, valid held high; transfer completes on the cycle ready rises.
- Word with end 0x0FFE < start 0x1000 → ack pulse, no frames. Then i_clip_done=1 → o_done=1 within 2 cycles and stays high through subsequent i_word_valid.
- i_rst asserted while frame 1 of 3 is pending → next cycle all outputs are 0. After reset, a new word is acked normally and framed starting at idx 0.

Source files
------------

// File: rtl/word_framer_pkg.sv
// Shared types and constants for the word framer: FSM state encoding, sample stride, default frame geometry.
package word_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EMIT,
    ST_DONE
  } state_t;

  localparam int SAMPLE_BYTES  = 2;
  localparam int DEF_FRAME_LEN = 400;
  localparam int DEF_FRAME_HOP = 160;

endpackage

// File: rtl/frame_addr_gen.sv
// Combinational frame geometry for frame idx of a word: addresses, emittable/pad flags, next-frame emittable.
// WORD_FRAMER_ZERO_PAD_EN: a partial tail frame (start inside the word) is emittable and flagged pad.
module frame_addr_gen
  import word_framer_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int FRAME_HOP = DEF_FRAME_HOP,
  parameter int ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0] word_start,
  input  logic [ADDR_W-1:0] word_end,
  input  logic [ADDR_W-1:0] idx,
  output logic [ADDR_W-1:0] frame_start,
  output logic [ADDR_W-1:0] frame_end,
  output logic              fit,
  output logic              pad,
  output logic              next_fit
);

  // Wide enough that idx*hop plus the word start can never wrap, so any
  // address beyond ADDR_W simply compares greater than the word end.
  localparam int WW = 2 * ADDR_W + 2;
  localparam logic [WW-1:0] HOP_B  = WW'(FRAME_HOP * SAMPLE_BYTES);
  localparam logic [WW-1:0] SPAN_B = WW'((FRAME_LEN - 1) * SAMPLE_BYTES);

  logic [WW-1:0] wend;
  logic [WW-1:0] start_w;
  logic [WW-1:0] end_w;
  logic [WW-1:0] nstart_w;
  logic          full;

  always_comb begin
    wend     = WW'(word_end);
    start_w  = WW'(word_start) + WW'(idx) * HOP_B;
    end_w    = start_w + SPAN_B;
    nstart_w = start_w + HOP_B;
    full     = (end_w <= wend);
  end

  assign frame_start = start_w[ADDR_W-1:0];
  assign frame_end   = end_w[ADDR_W-1:0];

`ifdef WORD_FRAMER_ZERO_PAD_EN
  assign fit      = (start_w <= wend);
  assign pad      = !full;
  assign next_fit = (nstart_w <= wend);
`else
  logic nfull;
  assign nfull    = ((nstart_w + SPAN_B) <= wend);
  assign fit      = full;
  assign pad      = 1'b0;
  assign next_fit = nfull;
`endif

endmodule

// File: rtl/word_framer.sv
// Acks clipped words and splits them into overlapping frame descriptors: ack at N+1, first frame at N+2, one frame/cycle.
// Descriptors hold while !i_frame_ready; WORD_FRAMER_ZERO_PAD_EN adds a padded tail frame.
module word_framer
  import word_framer_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int FRAME_HOP = DEF_FRAME_HOP,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_word_valid,
  input  logic [ADDR_W-1:0] i_word_start,
  input  logic [ADDR_W-1:0] i_word_end,
  input  logic              i_clip_done,
  output logic              o_word_ack,
  output logic              o_frame_valid,
  input  logic              i_frame_ready,
  output logic [ADDR_W-1:0] o_frame_start,
  output logic [ADDR_W-1:0] o_frame_end,
  output logic [IDX_W-1:0]  o_frame_idx,
  output logic              o_frame_last,
  output logic              o_frame_pad,
  output logic              o_done
);

  localparam int XW = ADDR_W + IDX_W;

  state_t            state;
  logic [ADDR_W-1:0] word_start;
  logic [ADDR_W-1:0] word_end;
  logic [ADDR_W-1:0] frame_cnt;
  logic [ADDR_W-1:0] gen_idx;
  logic [ADDR_W-1:0] gen_start;
  logic [ADDR_W-1:0] gen_end;
  logic              gen_fit;
  logic              gen_pad;
  logic              gen_next_fit;
  logic [IDX_W-1:0]  sat_idx;
  logic              load;

  // One generator serves both paths: frame 0 in CHECK, frame k+1 in EMIT.
  assign gen_idx = (state == ST_EMIT) ? frame_cnt + ADDR_W'(1) : '0;

  frame_addr_gen #(
    .FRAME_LEN (FRAME_LEN),
    .FRAME_HOP (FRAME_HOP),
    .ADDR_W    (ADDR_W)
  ) u_gen (
    .word_start  (word_start),
    .word_end    (word_end),
    .idx         (gen_idx),
    .frame_start (gen_start),
    .frame_end   (gen_end),
    .fit         (gen_fit),
    .pad         (gen_pad),
    .next_fit    (gen_next_fit)
  );

  always_comb begin
    if (XW'(gen_idx) > XW'({IDX_W{1'b1}})) sat_idx = '1;
    else                                    sat_idx = IDX_W'(gen_idx);
  end

  assign load = ((state == ST_CHECK) && !(word_end < word_start) && gen_fit) ||
                ((state == ST_EMIT) && i_frame_ready && !o_frame_last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      word_start    <= '0;
      word_end      <= '0;
      frame_cnt     <= '0;
      o_word_ack    <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frame_start <= '0;
      o_frame_end   <= '0;
      o_frame_idx   <= '0;
      o_frame_last  <= 1'b0;
      o_frame_pad   <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_word_ack <= 1'b0;

      if (load) begin
        frame_cnt     <= gen_idx;
        o_frame_valid <= 1'b1;
        o_frame_start <= gen_start;
        o_frame_end   <= gen_end;
        o_frame_idx   <= sat_idx;
        o_frame_last  <= !gen_next_fit;
        o_frame_pad   <= gen_pad;
      end

      case (state)
        ST_IDLE: begin
          if (i_word_valid) begin
            word_start <= i_word_start;
            word_end   <= i_word_end;
            o_word_ack <= 1'b1;
            state      <= ST_CHECK;
          end else if (i_clip_done) begin
            o_done <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_CHECK: state <= load ? ST_EMIT : ST_IDLE;
        ST_EMIT: begin
          if (i_frame_ready && o_frame_last) begin
            o_frame_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_DONE: o_done <= 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_framer.sv
// Bench for word_framer: queue-based frame model, per-cycle compare of accepted descriptors and hold behaviour.
module tb_word_framer;

  localparam int FL = 400;
  localparam int FH = 160;
`ifdef WORD_FRAMER_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] s;
    logic [31:0] e;
    logic [15:0] idx;
    logic        last;
    logic        pad;
  } fr_t;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_word_valid = 1'b0;
  logic [31:0] i_word_start = '0;
  logic [31:0] i_word_end = '0;
  logic        i_clip_done = 1'b0;
  logic        o_word_ack;
  logic        o_frame_valid;
  logic        i_frame_ready;
  logic [31:0] o_frame_start;
  logic [31:0] o_frame_end;
  logic [15:0] o_frame_idx;
  logic        o_frame_last;
  logic        o_frame_pad;
  logic        o_done;

  bit   rdy_mode = 1'b0;
  logic rdy_manual = 1'b1;
  logic rnd_rdy = 1'b1;
  assign i_frame_ready = rdy_mode ? rnd_rdy : rdy_manual;

  int  n_checks = 0;
  int  n_pass = 0;
  fr_t exp_q[$];
  fr_t got[$];

  always #5 clk = ~clk;

  word_framer #(
    .FRAME_LEN (FL),
    .FRAME_HOP (FH),
    .ADDR_W    (32),
    .IDX_W     (16)
  ) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_word_valid  (i_word_valid),
    .i_word_start  (i_word_start),
    .i_word_end    (i_word_end),
    .i_clip_done   (i_clip_done),
    .o_word_ack    (o_word_ack),
    .o_frame_valid (o_frame_valid),
    .i_frame_ready (i_frame_ready),
    .o_frame_start (o_frame_start),
    .o_frame_end   (o_frame_end),
    .o_frame_idx   (o_frame_idx),
    .o_frame_last  (o_frame_last),
    .o_frame_pad   (o_frame_pad),
    .o_done        (o_done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: list every frame of a word straight from the address rules.
  task automatic model_word(input logic [31:0] s, input logic [31:0] e);
    longint unsigned ls, le, st, en;
    fr_t tmp[$];
    fr_t f;
    ls = s;
    le = e;
    if (le >= ls) begin
      for (longint unsigned k = 0; k < 100000; k++) begin
        st = ls + k * FH * 2;
        en = st + (FL - 1) * 2;
        f = '0;
        f.s = st[31:0];
        f.e = en[31:0];
        f.idx = (k > 65535) ? 16'hFFFF : k[15:0];
        if (en <= le) begin
          tmp.push_back(f);
        end else begin
          if (PAD && st <= le) begin
            f.pad = 1'b1;
            tmp.push_back(f);
          end
          break;
        end
      end
    end
    foreach (tmp[i]) begin
      tmp[i].last = (i == tmp.size() - 1);
      exp_q.push_back(tmp[i]);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode) rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  initial begin : compare
    fr_t prev;
    fr_t cur;
    fr_t e;
    bit  pv;
    bit  pr;
    pv = 1'b0;
    pr = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {o_frame_start, o_frame_end, o_frame_idx, o_frame_last, o_frame_pad};
      if (i_rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) check("hold", {o_frame_valid, cur}, {1'b1, prev});
        if (o_frame_valid && i_frame_ready) begin
          check("frame_expected", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame", cur, e);
          end
          got.push_back(cur);
        end
        pv = o_frame_valid;
        pr = i_frame_ready;
        prev = cur;
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (o_frame_valid && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_bound", t < 5000, 1'b1);
    check("frames_left", exp_q.size(), 0);
  endtask

  task automatic send_word(input logic [31:0] s, input logic [31:0] e, input bit do_drain);
    int lat;
    model_word(s, e);
    i_word_start = s;
    i_word_end = e;
    i_word_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!o_word_ack && lat < 20);
    check("ack_latency", lat, 1);
    i_word_valid = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", o_word_ack, 1'b0);
    if (do_drain) drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int c;
    logic [31:0] s, e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", o_word_ack, 1'b0);
    check("rst_valid", o_frame_valid, 1'b0);
    check("rst_start", o_frame_start, 32'h0);
    check("rst_end", o_frame_end, 32'h0);
    check("rst_idx", o_frame_idx, 16'h0);
    check("rst_last", o_frame_last, 1'b0);
    check("rst_pad", o_frame_pad, 1'b0);
    check("rst_done", o_done, 1'b0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    // 720-sample word, ready held high
    got.delete();
    send_word(32'h1000, 32'h159E, 1'b1);
    check("A_count", got.size(), PAD ? 4 : 3);
    check("A_f0", got[0], {32'h1000, 32'h131E, 16'd0, 1'b0, 1'b0});
    check("A_f1", got[1], {32'h1140, 32'h145E, 16'd1, 1'b0, 1'b0});
    check("A_f2", got[2], {32'h1280, 32'h159E, 16'd2, !PAD, 1'b0});
`ifdef WORD_FRAMER_ZERO_PAD_EN
    check("A_f3", got[3], {32'h13C0, 32'h16DE, 16'd3, 1'b1, 1'b1});
`endif

    // 100-sample word, shorter than a frame
    got.delete();
    send_word(32'h2000, 32'h20C6, 1'b1);
    check("B_count", got.size(), PAD ? 1 : 0);
`ifdef WORD_FRAMER_ZERO_PAD_EN
    check("B_f0", got[0], {32'h2000, 32'h231E, 16'd0, 1'b1, 1'b1});
`endif

    // backpressure on frame 1
    got.delete();
    rdy_manual = 1'b0;
    send_word(32'h1000, 32'h159E, 1'b0);
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    rdy_manual = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", o_frame_valid, 1'b1);
      check("bp_idx", o_frame_idx, 16'd1);
    end
    check("bp_desc", {o_frame_start, o_frame_end, o_frame_last}, {32'h1140, 32'h145E, 1'b0});
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    check("bp_advance", o_frame_idx, 16'd2);
    check("bp_got", got.size(), 2);
    drain();

    // reset while frame 1 of 3 is pending
    rdy_manual = 1'b0;
    send_word(32'h1000, 32'h159E, 1'b0);
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    rdy_manual = 1'b0;
    check("pre_rst_idx", o_frame_idx, 16'd1);
    i_rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_outputs",
          {o_word_ack, o_frame_valid, o_frame_start, o_frame_end, o_frame_idx, o_frame_last, o_frame_pad, o_done},
          '0);
    exp_q.delete();
    i_rst = 1'b0;
    rdy_manual = 1'b1;
    got.delete();
    send_word(32'h1000, 32'h159E, 1'b1);
    check("post_rst_f0", got[0], {32'h1000, 32'h131E, 16'd0, 1'b0, 1'b0});
    check("post_rst_count", got.size(), PAD ? 4 : 3);

    // randomized words and random backpressure
    rdy_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 7);
      if (c == 0) begin
        s = 32'hFFFF_FF00 - 32'($urandom_range(0, 400)) * 2;
        e = 32'hFFFF_FFFE;
      end else if (c == 1) begin
        s = $urandom & 32'hFFFF_FFFE;
        e = $urandom & 32'hFFFF_FFFE;
      end else begin
        s = $urandom & 32'h0FFF_FFFE;
        e = s + 32'($urandom_range(0, 1400)) * 2 - 32'd2;
      end
      send_word(s, e, 1'b1);
    end
    rdy_mode = 1'b0;
    rdy_manual = 1'b1;

    // inverted word, then end of utterance
    got.delete();
    send_word(32'h1000, 32'h0FFE, 1'b1);
    check("inv_count", got.size(), 0);
    i_clip_done = 1'b1;
    c = 0;
    while (!o_done && c < 2) begin
      @(posedge clk); #1;
      c++;
    end
    check("done_rise", o_done, 1'b1);
    i_word_start = 32'h3000;
    i_word_end = 32'h4000;
    i_word_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("done_sticky", {o_done, o_word_ack, o_frame_valid}, 3'b100);
    end
    i_word_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
